ws2812_pattern_ctrl: RTL and testbench

//  Sequences frames for the ws2812 driver on the XO3D board.
//  The raw user button is synchronised and debounced; each press selects the next LED pattern mode.
//  A frame timer issues periodic frame_start requests, then streams NUM_PIXELS GRB words over valid/ready.
//  The block waits for the driver's frame_done before the next frame may start.

---
 rtl/ws2812_pattern_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ws2812_pattern_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pattern_ctrl.sv
// Frame sequencer for the ws2812 driver: debounces the mode button, paces frames
// with a free-running timer and streams NUM_PIXELS GRB words over valid/ready.
module ws2812_pattern_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int FRAME_CYCLES    = 600000,
    parameter int NUM_PIXELS      = 8,
    parameter int NUM_MODES       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        button,
    output logic        led,
    output logic [1:0]  mode,
    output logic        frame_start,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    input  logic        frame_done,
    output logic        frame_overrun
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int FT_W  = $clog2(FRAME_CYCLES);
    localparam int IDX_W = $clog2(NUM_PIXELS);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FT_W-1:0]  FT_LAST  = FT_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);
    localparam logic [1:0]       NM_LAST  = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_DONE
    } state_t;

    logic            btn_meta_q, btn_sync_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            debounced_q, debounced_d;
    logic [1:0]      next_mode_q, next_mode_d;
    logic            press;

    logic [FT_W-1:0] ft_cnt_q, ft_cnt_d;
    logic            tick;

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic             phase_q, phase_d;
    logic [23:0]      pixel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            db_cnt_q    <= '0;
            debounced_q <= 1'b0;
            next_mode_q <= 2'd0;
            ft_cnt_q    <= '0;
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            mode_q      <= 2'd0;
            index_q     <= '0;
            pos_q       <= '0;
            phase_q     <= 1'b0;
        end else begin
            btn_meta_q  <= button;
            btn_sync_q  <= btn_meta_q;
            db_cnt_q    <= db_cnt_d;
            debounced_q <= debounced_d;
            next_mode_q <= next_mode_d;
            ft_cnt_q    <= ft_cnt_d;
            state_q     <= state_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            index_q     <= index_d;
            pos_q       <= pos_d;
            phase_q     <= phase_d;
        end
    end

    // NOTE: every variable gets a default before any branch, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        debounced_d = debounced_q;
        if (btn_sync_q == debounced_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            debounced_d = btn_sync_q;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign press       = debounced_d & ~debounced_q;
    assign next_mode_d = !press ? next_mode_q
                       : (next_mode_q == NM_LAST) ? 2'd0 : next_mode_q + 2'd1;

    assign tick     = (ft_cnt_q == FT_LAST);
    assign ft_cnt_d = tick ? '0 : ft_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        mode_d        = mode_q;
        index_d       = index_q;
        pos_d         = pos_q;
        phase_d       = phase_q;
        frame_overrun = 1'b0;

        // At most one tick is remembered while a frame is in flight.
        if (tick && (state_q != S_IDLE)) begin
            if (pending_q) frame_overrun = 1'b1;
            else           pending_d     = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick || pending_q) begin
                    state_d   = S_START;
                    pending_d = 1'b0;
                end
            end
            S_START: begin
                mode_d  = next_mode_q;
                index_d = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (pix_ready) begin
                    index_d = index_q + 1'b1;
                    if (index_q == IDX_LAST) state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (frame_done) begin
                    state_d = S_IDLE;
                    pos_d   = (pos_q == IDX_LAST) ? '0 : pos_q + 1'b1;
                    phase_d = ~phase_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pixel = 24'h000000;
        case (mode_q)
            2'd1:    pixel = 24'h101010;
            2'd2:    pixel = (index_q == pos_q) ? 24'h00FF00 : 24'h000000;
            2'd3:    pixel = (index_q[0] ^ phase_q) ? 24'h0000FF : 24'hFF0000;
            default: pixel = 24'h000000;
        endcase
    end

    assign led         = debounced_q;
    assign mode        = mode_q;
    assign frame_start = (state_q == S_START);
    assign pix_valid   = (state_q == S_STREAM);
    assign pix_data    = pix_valid ? pixel : 24'h000000;

endmodule

// File: tb/tb_ws2812_pattern_ctrl.sv
// Self-checking bench for ws2812_pattern_ctrl: a transaction-level model predicts
// every output each cycle; directed scenarios add hand-computed expectations.
module tb_ws2812_pattern_ctrl;

    localparam int DEB    = 4;
    localparam int FRM    = 32;
    localparam int NPIX   = 4;
    localparam int NMODES = 4;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        button     = 1'b0;
    logic        pix_ready  = 1'b1;
    logic        frame_done = 1'b0;
    logic        led;
    logic [1:0]  mode;
    logic        frame_start;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        frame_overrun;

    int tests = 0;
    int fails = 0;

    ws2812_pattern_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .FRAME_CYCLES   (FRM),
        .NUM_PIXELS     (NPIX),
        .NUM_MODES      (NMODES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button       (button),
        .led          (led),
        .mode         (mode),
        .frame_start  (frame_start),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [23:0] pattern(input int m, input int idx, input int p, input int ph);
        case (m)
            1:       return 24'h101010;
            2:       return (idx == p) ? 24'h00FF00 : 24'h000000;
            3:       return (((idx + ph) % 2) == 0) ? 24'hFF0000 : 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    int          m_cyc;
    bit          m_busy, m_start, m_pend, m_deb, m_tick, m_all_diff;
    int          m_mode, m_next, m_pos, m_phase;
    logic [23:0] m_words[$];
    bit          m_hist[$];  // raw button samples, newest first

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_busy = 0; m_start = 0; m_pend = 0; m_deb = 0;
            m_mode = 0; m_next = 0; m_pos = 0; m_phase = 0;
            m_words = {};
            m_hist = {};
            repeat (DEB + 2) m_hist.push_back(1'b0);
        end else begin
            m_tick = ((m_cyc % FRM) == FRM - 1);
            if (!m_busy) begin
                if (m_tick || m_pend) begin
                    m_busy = 1; m_start = 1; m_pend = 0;
                end
            end else begin
                if (m_tick && !m_pend) m_pend = 1;
                if (m_start) begin
                    m_start = 0;
                    m_mode  = m_next;
                    m_words = {};
                    for (int i = 0; i < NPIX; i++) m_words.push_back(pattern(m_next, i, m_pos, m_phase));
                end else if (m_words.size() > 0) begin
                    if (pix_ready) void'(m_words.pop_front());
                end else if (frame_done) begin
                    m_busy  = 0;
                    m_pos   = (m_pos + 1) % NPIX;
                    m_phase = 1 - m_phase;
                end
            end
            m_cyc++;
            // Two sync stages delay the button by two edges; the debounced level
            // flips once DEB consecutive synced samples disagree with it.
            m_hist.push_front(button);
            void'(m_hist.pop_back());
            m_all_diff = 1;
            for (int i = 2; i < DEB + 2; i++) if (m_hist[i] == m_deb) m_all_diff = 0;
            if (m_all_diff) begin
                if (!m_deb) m_next = (m_next + 1) % NMODES;
                m_deb = !m_deb;
            end
        end
    end

    bit exp_valid;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs",
                  32'({led, mode, frame_start, pix_valid, frame_overrun, pix_data}), 32'd0);
        end else begin
            exp_valid = m_busy && !m_start && (m_words.size() > 0);
            check("led", led, m_deb);
            check("mode", mode, m_mode);
            check("frame_start", frame_start, m_start);
            check("pix_valid", pix_valid, exp_valid);
            if (exp_valid) check("pix_data", pix_data, m_words[0]);
            check("frame_overrun", frame_overrun,
                  m_busy && m_pend && ((m_cyc % FRM) == FRM - 1));
        end
    end

    // ---------------- monitors / driver-side responder ----------------
    int          cyc_tb;
    logic [23:0] got[$];
    int          frame_words, last_xfer_cnt, overruns;
    bit          stalled;
    logic [23:0] stall_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_tb = 0;
        else        cyc_tb++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            frame_words = 0;
            stalled     = 0;
        end else begin
            if (frame_start) frame_words = 0;
            if (frame_overrun) overruns++;
            if (stalled) begin
                check("stall_hold_valid", pix_valid, 1);
                check("stall_hold_data", pix_data, stall_data);
            end
            stalled    = pix_valid && !pix_ready;
            stall_data = pix_data;
            if (pix_valid && pix_ready) begin
                got.push_back(pix_data);
                frame_words++;
                if (frame_words == NPIX) last_xfer_cnt++;
            end
        end
    end

    int done_delay = 0;
    bit rand_ready = 0;
    int done_wait  = -1;
    int xfer_ack   = 0;

    always @(posedge clk) begin
        #1;
        frame_done = 1'b0;
        if (!rst_n) begin
            done_wait = -1;
            xfer_ack  = last_xfer_cnt;
        end else begin
            if (last_xfer_cnt != xfer_ack) begin
                xfer_ack  = last_xfer_cnt;
                done_wait = done_delay;
            end
            if (done_wait == 0) begin
                frame_done = 1'b1;
                done_wait  = -1;
            end else if (done_wait > 0) begin
                done_wait--;
            end
        end
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- stimulus ----------------
    // which: 0 = frame_start, 1 = frame_done. Returns aligned #1 after the next edge.
    task automatic wait_event(input int which, input int limit, input string name, output int at_cyc);
        int n   = 0;
        bit hit = 0;
        at_cyc = -1;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? frame_start : frame_done;
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL %s: no event within %0d cycles", name, limit);
        end else begin
            at_cyc = cyc_tb;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic press();
        button = 1'b1;
        repeat (7) @(posedge clk);
        #1 button = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    logic [23:0] m3_exp [2][NPIX] = '{'{24'h0000FF, 24'hFF0000, 24'h0000FF, 24'hFF0000},
                                      '{24'hFF0000, 24'h0000FF, 24'hFF0000, 24'h0000FF}};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start, t_done, t_done2, base, ov0, n;

        // 1: first frame after reset release, all-black words
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_event(0, 100, "first_start", t_start);
        check("first_start_cycle", t_start, 32);
        base = got.size();
        wait_event(1, 20, "first_done", t_done);
        check("first_frame_words", got.size() - base, NPIX);
        if (got.size() - base == NPIX)
            for (int i = 0; i < NPIX; i++) check("mode0_word", got[base + i], 24'h000000);

        // 2: short glitch ignored, long press advances mode
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1 button = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("short_press_led", led, 0);
        check("short_press_mode", mode, 0);
        button = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("long_press_led", led, 1);
        button = 1'b0;
        wait_event(0, 100, "mode1_start", t_start);
        base = got.size();
        wait_event(1, 20, "mode1_done", t_done);
        check("mode1_mode", mode, 1);
        check("mode1_words", got.size() - base, NPIX);
        if (got.size() - base == NPIX)
            for (int i = 0; i < NPIX; i++) check("mode1_word", got[base + i], 24'h101010);

        // 3: chase in mode 2 over five frames, then mode 3 checkerboard
        do_reset();
        press();
        press();
        for (int k = 0; k < 5; k++) begin
            wait_event(0, 100, "mode2_start", t_start);
            base = got.size();
            wait_event(1, 20, "mode2_done", t_done);
            check("mode2_mode", mode, 2);
            check("mode2_words", got.size() - base, NPIX);
            if (got.size() - base == NPIX)
                for (int i = 0; i < NPIX; i++)
                    check("mode2_chase", got[base + i], (i == k % NPIX) ? 24'h00FF00 : 24'h000000);
        end
        press();
        for (int k = 0; k < 2; k++) begin
            wait_event(0, 100, "mode3_start", t_start);
            base = got.size();
            wait_event(1, 20, "mode3_done", t_done);
            check("mode3_mode", mode, 3);
            check("mode3_words", got.size() - base, NPIX);
            if (got.size() - base == NPIX)
                for (int i = 0; i < NPIX; i++) check("mode3_word", got[base + i], m3_exp[k][i]);
        end

        // 4: random back-pressure
        rand_ready = 1;
        wait_event(0, 100, "rand_start", t_start);
        base = got.size();
        wait_event(1, 200, "rand_done", t_done);
        rand_ready = 0;
        @(posedge clk);
        #1;
        check("rand_xfers", got.size() - base, NPIX);

        // 5: late frame_done -> pending tick, then overrun
        wait_event(0, 100, "late40_start", t_start);
        done_delay = 40;
        ov0 = overruns;
        wait_event(1, 100, "late40_done", t_done);
        done_delay = 0;
        wait_event(0, 10, "pending_start", t_start);
        check("pending_start_gap", t_start - t_done, 2);
        check("late40_no_overrun", overruns - ov0, 0);
        wait_event(0, 100, "late70_start", t_start);
        done_delay = 70;
        ov0 = overruns;
        wait_event(1, 150, "late70_done", t_done2);
        done_delay = 0;
        check("late70_overrun_once", overruns - ov0, 1);

        // 6: reset in the middle of streaming
        wait_event(0, 100, "rst_frame_start", t_start);
        base = got.size();
        n = 0;
        while (got.size() < base + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_stream_reached", got.size() - base, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_drop_valid", pix_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_event(0, 100, "post_rst_start", t_start);
        check("post_rst_start_cycle", t_start, 32);
        base = got.size();
        wait_event(1, 20, "post_rst_done", t_done);
        check("post_rst_mode", mode, 0);
        check("post_rst_words", got.size() - base, NPIX);
        if (got.size() - base == NPIX)
            for (int i = 0; i < NPIX; i++) check("post_rst_word", got[base + i], 24'h000000);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
